// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS pipeline control logic.
package mips_pkg;

    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        HZ_RUN,
        HZ_WAIT
    } hz_state_e;

    // A later stage supplies a source operand; register 0 is hard-wired and never matches.
    function automatic logic reg_match(input logic             we,
                                       input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/forward_unit.sv
// EX-stage operand forwarding select for one ALU source operand.
module forward_unit
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] writereg_mem,
    input  logic             regwrite_mem,
    input  logic [REG_W-1:0] writereg_wb,
    input  logic             regwrite_wb,
    output fwd_sel_e         sel
);

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        sel = FWD_RF;
        if (reg_match(regwrite_mem, writereg_mem, src)) begin
            sel = FWD_MEM;
        end else if (reg_match(regwrite_wb, writereg_wb, src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush/hold priority, forwarding, dmem wait
// sequencing with timeout, and saturating event counters.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic [REG_W-1:0] rs_EX,
    input  logic [REG_W-1:0] rt_EX,
    input  logic [REG_W-1:0] writereg_EX,
    input  logic             regwrite_EX,
    input  logic             memtoreg_EX,
    input  logic [REG_W-1:0] writereg_MEM,
    input  logic             regwrite_MEM,
    input  logic [REG_W-1:0] writereg_WB,
    input  logic             regwrite_WB,
    input  logic             branch_taken_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             stall_F,
    output logic             stall_D,
    output logic             flush_D,
    output logic             flush_E,
    output logic             hold_E,
    output logic             hold_M,
    output logic [1:0]       forward_a_EX,
    output logic [1:0]       forward_b_EX,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             timeout_err
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

    hz_state_e          state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               freeze, load_use, branch;
    logic               lu_evt, br_evt;
    fwd_sel_e           fwd_a, fwd_b;

    assign freeze   = dmem_req_MEM && !dmem_ready;
    assign branch   = branch_taken_EX;
    assign load_use = memtoreg_EX && (reg_match(regwrite_EX, writereg_EX, rs_ID) ||
                                      reg_match(regwrite_EX, writereg_EX, rt_ID));

    forward_unit u_fwd_a (
        .src          (rs_EX),
        .writereg_mem (writereg_MEM),
        .regwrite_mem (regwrite_MEM),
        .writereg_wb  (writereg_WB),
        .regwrite_wb  (regwrite_WB),
        .sel          (fwd_a)
    );

    forward_unit u_fwd_b (
        .src          (rt_EX),
        .writereg_mem (writereg_MEM),
        .regwrite_mem (regwrite_MEM),
        .writereg_wb  (writereg_WB),
        .regwrite_wb  (regwrite_WB),
        .sel          (fwd_b)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= HZ_RUN;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            HZ_RUN: begin
                if (freeze) begin
                    state_d = HZ_WAIT;
                    timer_d = TIMER_W'(1);
                end
            end
            HZ_WAIT: begin
                if (freeze) begin
                    if (timer_q != TIMER_MAX) begin
                        timer_d = timer_q + 1'b1;
                    end
                end else begin
                    state_d = HZ_RUN;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = HZ_RUN;
                timer_d = '0;
            end
        endcase
    end

    // Freeze outranks branch and load-use; those stay presented while frozen.
    always_comb begin
        stall_F      = 1'b0;
        stall_D      = 1'b0;
        flush_D      = 1'b0;
        flush_E      = 1'b0;
        hold_E       = 1'b0;
        hold_M       = 1'b0;
        lu_evt       = 1'b0;
        br_evt       = 1'b0;
        forward_a_EX = FWD_RF;
        forward_b_EX = FWD_RF;
        if (reset_n) begin
            forward_a_EX = fwd_a;
            forward_b_EX = fwd_b;
            if (freeze) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                hold_E  = 1'b1;
                hold_M  = 1'b1;
            end else if (branch) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
                br_evt  = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
                lu_evt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (lu_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (br_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
            if (freeze && (wait_cnt != '1))  wait_cnt  <= wait_cnt + 1'b1;
            if (freeze && (timer_d == TIMER_MAX)) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: spec-level model compared every cycle plus literal pins.
module tb_hazard_unit;

    localparam int unsigned CNT_W   = 3;
    localparam int unsigned TIMEOUT = 4;
    localparam int          SAT     = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] rs_ID, rt_ID, rs_EX, rt_EX, writereg_EX, writereg_MEM, writereg_WB;
    logic       regwrite_EX, memtoreg_EX, regwrite_MEM, regwrite_WB;
    logic       branch_taken_EX, dmem_req_MEM, dmem_ready;
    logic       stall_F, stall_D, flush_D, flush_E, hold_E, hold_M, timeout_err;
    logic [1:0] forward_a_EX, forward_b_EX;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    int m_stall, m_flush, m_wait, m_run;
    bit m_err;

    always #5 clk = ~clk;

    hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rs_ID           (rs_ID),
        .rt_ID           (rt_ID),
        .rs_EX           (rs_EX),
        .rt_EX           (rt_EX),
        .writereg_EX     (writereg_EX),
        .regwrite_EX     (regwrite_EX),
        .memtoreg_EX     (memtoreg_EX),
        .writereg_MEM    (writereg_MEM),
        .regwrite_MEM    (regwrite_MEM),
        .writereg_WB     (writereg_WB),
        .regwrite_WB     (regwrite_WB),
        .branch_taken_EX (branch_taken_EX),
        .dmem_req_MEM    (dmem_req_MEM),
        .dmem_ready      (dmem_ready),
        .stall_F         (stall_F),
        .stall_D         (stall_D),
        .flush_D         (flush_D),
        .flush_E         (flush_E),
        .hold_E          (hold_E),
        .hold_M          (hold_M),
        .forward_a_EX    (forward_a_EX),
        .forward_b_EX    (forward_b_EX),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .wait_cnt        (wait_cnt),
        .timeout_err     (timeout_err)
    );

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit is_load_use();
        return memtoreg_EX && regwrite_EX && (writereg_EX != 0) &&
               ((writereg_EX == rs_ID) || (writereg_EX == rt_ID));
    endfunction

    function automatic int exp_fwd(input logic [4:0] src);
        if (regwrite_MEM && (writereg_MEM != 0) && (writereg_MEM == src)) return 2;
        if (regwrite_WB && (writereg_WB != 0) && (writereg_WB == src)) return 1;
        return 0;
    endfunction

    // Model: event counts and run length of consecutive frozen cycles.
    always @(posedge clk) begin
        bit fz;
        fz = dmem_req_MEM && !dmem_ready;
        if (!reset_n) begin
            m_stall = 0; m_flush = 0; m_wait = 0; m_run = 0; m_err = 1'b0;
        end else if (fz) begin
            if (m_wait < SAT) m_wait++;
            if (m_run < TIMEOUT) m_run++;
            if (m_run == TIMEOUT) m_err = 1'b1;
        end else begin
            m_run = 0;
            if (branch_taken_EX) begin
                if (m_flush < SAT) m_flush++;
            end else if (is_load_use()) begin
                if (m_stall < SAT) m_stall++;
            end
        end
    end

    always @(negedge clk) begin
        bit fz, e_sf, e_sd, e_fd, e_fe, e_he, e_hm;
        int e_fa, e_fb;
        if (cmp_en) begin
            fz = dmem_req_MEM && !dmem_ready;
            e_sf = 0; e_sd = 0; e_fd = 0; e_fe = 0; e_he = 0; e_hm = 0;
            e_fa = 0; e_fb = 0;
            if (reset_n) begin
                e_fa = exp_fwd(rs_EX);
                e_fb = exp_fwd(rt_EX);
                if (fz) begin
                    e_sf = 1; e_sd = 1; e_he = 1; e_hm = 1;
                end else if (branch_taken_EX) begin
                    e_fd = 1; e_fe = 1;
                end else if (is_load_use()) begin
                    e_sf = 1; e_sd = 1; e_fe = 1;
                end
            end
            check("stall_F", stall_F, e_sf);
            check("stall_D", stall_D, e_sd);
            check("flush_D", flush_D, e_fd);
            check("flush_E", flush_E, e_fe);
            check("hold_E", hold_E, e_he);
            check("hold_M", hold_M, e_hm);
            check("forward_a_EX", forward_a_EX, e_fa);
            check("forward_b_EX", forward_b_EX, e_fb);
            check("stall_cnt", stall_cnt, m_stall);
            check("flush_cnt", flush_cnt, m_flush);
            check("wait_cnt", wait_cnt, m_wait);
            check("timeout_err", timeout_err, m_err);
        end
    end

    task automatic idle();
        rs_ID = 0; rt_ID = 0; rs_EX = 0; rt_EX = 0;
        writereg_EX = 0; writereg_MEM = 0; writereg_WB = 0;
        regwrite_EX = 0; memtoreg_EX = 0; regwrite_MEM = 0; regwrite_WB = 0;
        branch_taken_EX = 0; dmem_req_MEM = 0; dmem_ready = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_r8();
        memtoreg_EX = 1; regwrite_EX = 1; writereg_EX = 8; rs_ID = 8;
    endtask

    initial begin
        reset_n = 0;
        idle();
        step();
        cmp_en = 1'b1;
        step();
        check("rst stall_cnt", stall_cnt, 0);
        check("rst wait_cnt", wait_cnt, 0);
        check("rst timeout_err", timeout_err, 0);

        // Outputs are gated while reset is held, whatever the inputs.
        load_use_r8(); branch_taken_EX = 1; dmem_req_MEM = 1;
        writereg_MEM = 8; regwrite_MEM = 1; rs_EX = 8;
        #1;
        check("rst gate hold_E", hold_E, 0);
        check("rst gate flush_D", flush_D, 0);
        check("rst gate fwd_a", forward_a_EX, 0);
        step();
        idle();
        reset_n = 1;
        step();

        // Load-use for one cycle.
        load_use_r8();
        #1;
        check("lu stall_F", stall_F, 1);
        check("lu flush_E", flush_E, 1);
        step();
        idle();
        #1;
        check("lu released stall_F", stall_F, 0);
        check("lu stall_cnt", stall_cnt, 1);
        step();

        // Forwarding priority and register 0.
        writereg_MEM = 8; regwrite_MEM = 1; writereg_WB = 8; regwrite_WB = 1;
        rs_EX = 8; rt_EX = 3;
        #1;
        check("fwd mem", forward_a_EX, 2);
        check("fwd b none", forward_b_EX, 0);
        regwrite_MEM = 0;
        #1;
        check("fwd wb", forward_a_EX, 1);
        writereg_MEM = 0; writereg_WB = 0; regwrite_MEM = 1; rs_EX = 0;
        #1;
        check("fwd r0", forward_a_EX, 0);
        rt_EX = 3; writereg_WB = 3;
        #1;
        check("fwd b wb", forward_b_EX, 1);
        step();
        idle();

        // Branch suppresses load-use.
        load_use_r8(); branch_taken_EX = 1;
        #1;
        check("br flush_D", flush_D, 1);
        check("br stall_F", stall_F, 0);
        step();
        idle();
        check("br flush_cnt", flush_cnt, 1);
        check("br stall_cnt", stall_cnt, 1);

        // Three wait cycles with a pending branch, then ready.
        dmem_req_MEM = 1; dmem_ready = 0; branch_taken_EX = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("wait hold_M", hold_M, 1);
            check("wait flush_D", flush_D, 0);
            step();
        end
        dmem_ready = 1;
        #1;
        check("ready hold_E", hold_E, 0);
        check("ready flush_D", flush_D, 1);
        step();
        idle();
        check("wait wait_cnt", wait_cnt, 3);
        check("wait flush_cnt", flush_cnt, 2);
        check("wait no timeout", timeout_err, 0);

        // Timeout after the TIMEOUT-th frozen edge; sticky.
        dmem_req_MEM = 1; dmem_ready = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("timeout edge", timeout_err, (i >= 4) ? 1 : 0);
        end
        dmem_ready = 1;
        step();
        idle();
        step();
        check("timeout sticky", timeout_err, 1);
        check("wait_cnt sat", wait_cnt, SAT);

        // Counter saturation.
        load_use_r8();
        repeat (8) step();
        idle();
        check("stall_cnt sat", stall_cnt, SAT);
        branch_taken_EX = 1;
        repeat (6) step();
        idle();
        check("flush_cnt sat", flush_cnt, SAT);

        // Mixed vectors; the compare process checks every cycle.
        for (int i = 0; i < 200; i++) begin
            rs_ID = 5'($urandom_range(0, 3)); rt_ID = 5'($urandom_range(0, 3));
            rs_EX = 5'($urandom_range(0, 3)); rt_EX = 5'($urandom_range(0, 3));
            writereg_EX = 5'($urandom_range(0, 3));
            writereg_MEM = 5'($urandom_range(0, 3));
            writereg_WB = 5'($urandom_range(0, 3));
            regwrite_EX = 1'($urandom); memtoreg_EX = 1'($urandom);
            regwrite_MEM = 1'($urandom); regwrite_WB = 1'($urandom);
            branch_taken_EX = ($urandom_range(0, 3) == 0);
            dmem_req_MEM = ($urandom_range(0, 2) == 0); dmem_ready = 1'($urandom);
            step();
        end
        idle();
        step();

        // Reset in the middle of a wait.
        dmem_req_MEM = 1; dmem_ready = 0;
        step();
        step();
        reset_n = 0;
        writereg_MEM = 8; regwrite_MEM = 1; rs_EX = 8;
        #1;
        check("midrst hold_E", hold_E, 0);
        check("midrst stall_F", stall_F, 0);
        check("midrst fwd_a", forward_a_EX, 0);
        step();
        check("midrst wait_cnt", wait_cnt, 0);
        check("midrst stall_cnt", stall_cnt, 0);
        check("midrst flush_cnt", flush_cnt, 0);
        check("midrst timeout_err", timeout_err, 0);
        reset_n = 1;
        idle();
        dmem_req_MEM = 1;
        repeat (3) step();
        check("post rst timer", timeout_err, 0);
        check("post rst wait_cnt", wait_cnt, 3);
        dmem_ready = 1;
        step();
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
